// File: rtl/alu_issue_buffer.sv
// Issue buffer in front of a combinational ALU: a FIFO of pending operations,
// a registered result slot toward writeback, and a saturating overflow counter.
module alu_issue_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [OP_WIDTH-1:0]   in_op,
    output logic                  alu_enable,
    output logic [DATA_WIDTH-1:0] alu_src1,
    output logic [DATA_WIDTH-1:0] alu_src2,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_overflow,
    output logic [OP_WIDTH-1:0]   out_op,
    output logic [7:0]            ovf_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] src1_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] src1_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] src2_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] src2_mem_d [DEPTH];
    logic [OP_WIDTH-1:0]   op_mem_q   [DEPTH];
    logic [OP_WIDTH-1:0]   op_mem_d   [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
    logic                  out_overflow_q, out_overflow_d;
    logic [OP_WIDTH-1:0]   out_op_q, out_op_d;
    logic [7:0]            ovf_count_q, ovf_count_d;

    logic                  not_empty;
    logic                  push;
    logic                  fire;

    assign not_empty  = (count_q != '0);
    assign in_ready   = (count_q != FULL_CNT);
    assign push       = in_valid & in_ready;
    assign fire       = not_empty & (~out_valid_q | out_ready);
    assign alu_enable = fire;

    // Head operands are gated to zero when empty so the ALU sees a quiet bus.
    assign alu_src1 = not_empty ? src1_mem_q[rd_ptr_q] : '0;
    assign alu_src2 = not_empty ? src2_mem_q[rd_ptr_q] : '0;
    assign alu_op   = not_empty ? op_mem_q[rd_ptr_q]   : '0;

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_overflow = out_overflow_q;
    assign out_op       = out_op_q;
    assign ovf_count    = ovf_count_q;

    always_comb begin
        src1_mem_d     = src1_mem_q;
        src2_mem_d     = src2_mem_q;
        op_mem_d       = op_mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        out_valid_d    = out_valid_q;
        out_result_d   = out_result_q;
        out_overflow_d = out_overflow_q;
        out_op_d       = out_op_q;
        ovf_count_d    = ovf_count_q;

        if (push) begin
            src1_mem_d[wr_ptr_q] = in_src1;
            src2_mem_d[wr_ptr_q] = in_src2;
            op_mem_d[wr_ptr_q]   = in_op;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        if (fire) begin
            out_valid_d    = 1'b1;
            out_result_d   = alu_result;
            out_overflow_d = alu_overflow;
            out_op_d       = op_mem_q[rd_ptr_q];
            rd_ptr_d       = rd_ptr_q + 1'b1;
            if (alu_overflow && (ovf_count_q != 8'hFF)) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case ({push, fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                src1_mem_q[i] <= '0;
                src2_mem_q[i] <= '0;
                op_mem_q[i]   <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_overflow_q <= 1'b0;
            out_op_q       <= '0;
            ovf_count_q    <= '0;
        end else begin
            src1_mem_q     <= src1_mem_d;
            src2_mem_q     <= src2_mem_d;
            op_mem_q       <= op_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_overflow_q <= out_overflow_d;
            out_op_q       <= out_op_d;
            ovf_count_q    <= ovf_count_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_buffer.sv
// Bench for alu_issue_buffer with an adder ALU stub; results are checked
// against a scoreboard of expected values queued as operations are accepted.
module tb_alu_issue_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [3:0]  in_op;
    logic        alu_enable;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic [3:0]  out_op;
    logic [7:0]  ovf_count;

    alu_issue_buffer #(.DATA_WIDTH(32), .OP_WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op),
        .alu_enable(alu_enable), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_op(alu_op), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_op(out_op),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    assign alu_result   = alu_src1 + alu_src2;
    assign alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_result[31] != alu_src1[31]);

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic [3:0]  op;
    } exp_t;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  op;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    exp_t        sb[$];
    exp_t        drv_exp;
    int          passed = 0;
    int          total  = 0;
    int          outs   = 0;
    int          exp_ovf = 0;
    logic        in_acc = 1'b0;
    logic        rand_ready = 1'b0;
    logic        hold_prev = 1'b0;
    logic [36:0] prev_out;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Sampled on the falling edge: records what the next rising edge will transfer.
    task automatic monitor();
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_ovf   = 0;
            hold_prev = 1'b0;
            in_acc    = 1'b0;
            return;
        end
        if (hold_prev) chk("stall_hold", {31'd0, out_valid, out_result, out_overflow, out_op},
                           {31'd0, 1'b1, prev_out});
        in_acc = in_valid && in_ready;
        if (in_acc) sb.push_back(drv_exp);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_out: got result 0x%0h, expected no output", out_result);
            end else begin
                e = sb.pop_front();
                chk("out_data", {27'd0, out_result, out_overflow, out_op}, {27'd0, e.res, e.ovf, e.op});
                if (e.ovf && exp_ovf != 255) exp_ovf++;
            end
            outs++;
        end
        hold_prev = out_valid && !out_ready;
        prev_out  = {out_result, out_overflow, out_op};
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] er, input logic eo);
        int n;
        in_valid = 1'b1;
        in_src1  = a;
        in_src2  = b;
        in_op    = op;
        drv_exp  = '{res: er, ovf: eo, op: op};
        n = 0;
        do begin
            cycle();
            n++;
        end while (!in_acc && n < 200);
        if (!in_acc) chk("push_timeout", 64'(n), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 1000) begin
            cycle();
            n++;
        end
        chk("drain_done", {63'd0, (sb.size() == 0 && !out_valid)}, 64'd1);
    endtask

    task automatic chk_empty(input string name);
        chk(name, {27'd0, alu_enable, alu_src1, alu_src2[3:0], alu_op},
            {27'd0, 1'b0, 32'd0, 4'd0, 4'd0});
        chk({name, "_src2"}, 64'(alu_src2), 64'd0);
    endtask

    function automatic logic [32:0] add_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        return {((a[31] == b[31]) && (s[31] != a[31])), s};
    endfunction

    initial begin
        int k;
        logic [32:0] m;
        vecs[0] = '{src1: 32'h3,        src2: 32'h9,        op: 4'h0, res: 32'hC,        ovf: 1'b0};
        vecs[1] = '{src1: 32'h7FFFFFFF, src2: 32'h1,        op: 4'h1, res: 32'h80000000, ovf: 1'b1};
        vecs[2] = '{src1: 32'hFFFFFFFF, src2: 32'h1,        op: 4'h2, res: 32'h0,        ovf: 1'b0};
        vecs[3] = '{src1: 32'h80000000, src2: 32'h80000000, op: 4'h3, res: 32'h0,        ovf: 1'b1};
        vecs[4] = '{src1: 32'h12345678, src2: 32'h11111111, op: 4'h4, res: 32'h23456789, ovf: 1'b0};
        vecs[5] = '{src1: 32'hFFFFFFFE, src2: 32'hFFFFFFFE, op: 4'hF, res: 32'hFFFFFFFC, ovf: 1'b0};
        vecs[6] = '{src1: 32'h40000000, src2: 32'h40000000, op: 4'h8, res: 32'h80000000, ovf: 1'b1};
        vecs[7] = '{src1: 32'h0,        src2: 32'h0,        op: 4'hA, res: 32'h0,        ovf: 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_op = '0; out_ready = 1'b0;
        drv_exp = '0; prev_out = '0;
        #1;
        chk("reset_out", {26'd0, in_ready, out_valid, out_result, out_overflow, out_op},
            {26'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0});
        chk("reset_ovf_count", 64'(ovf_count), 64'd0);
        chk_empty("reset_alu");
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // Mid-stream reset: one result in the slot and three ops queued.
        out_ready = 1'b0;
        push_op(32'h1, 32'h1, 4'h1, 32'h2, 1'b0);
        push_op(32'h7FFFFFFF, 32'h7FFFFFFF, 4'h2, 32'hFFFFFFFE, 1'b1);
        push_op(32'h3, 32'h3, 4'h3, 32'h6, 1'b0);
        push_op(32'h4, 32'h4, 4'h4, 32'h8, 1'b0);
        chk("pre_reset_valid", {62'd0, out_valid, alu_enable}, {62'd0, 1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk("midreset_out", {26'd0, in_ready, out_valid, out_result, out_overflow, out_op},
            {26'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0});
        chk("midreset_ovf_count", 64'(ovf_count), 64'd0);
        chk_empty("midreset_alu");
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        push_op(32'h5, 32'h2, 4'h6, 32'h7, 1'b0);
        drain();
        chk("after_reset_outs", 64'(outs), 64'd1);

        // Single op latency.
        push_op(32'h3, 32'h9, 4'h0, 32'hC, 1'b0);
        chk("latency_not_early", {63'd0, out_valid}, 64'd0);
        cycle();
        chk("single_op", {26'd0, out_valid, out_result, out_overflow, out_op},
            {26'd0, 1'b1, 32'hC, 1'b0, 4'h0});
        drain();
        chk_empty("empty_alu");

        // Table vectors, back to back.
        for (int i = 0; i < 8; i++) push_op(vecs[i].src1, vecs[i].src2, vecs[i].op, vecs[i].res, vecs[i].ovf);
        drain();

        // Backpressure: slot holds the first, four more fill the FIFO.
        out_ready = 1'b0;
        push_op(32'hCC, 32'hAA, 4'h1, 32'h176, 1'b0);
        push_op(32'hE, 32'h7, 4'h2, 32'h15, 1'b0);
        push_op(32'h100, 32'h23, 4'h3, 32'h123, 1'b0);
        push_op(32'hFFFFFFFF, 32'h2, 4'h4, 32'h1, 1'b0);
        push_op(32'h80000000, 32'hFFFFFFFF, 4'h5, 32'h7FFFFFFF, 1'b1);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_slot", {27'd0, out_valid, out_result, out_op, alu_enable},
            {27'd0, 1'b1, 32'h176, 4'h1, 1'b0});
        chk("full_head", 64'(alu_src1), 64'hE);
        cycle();
        chk("full_still_held", {31'd0, out_valid, out_result}, {31'd0, 1'b1, 32'h176});
        k = outs;
        out_ready = 1'b1;
        push_op(32'h11, 32'h22, 4'h6, 32'h33, 1'b0);
        repeat (4) cycle();
        chk("drain_rate", 64'(outs - k), 64'd6);
        cycle();
        chk("valid_falls", {63'd0, out_valid}, 64'd0);
        chk_empty("drained_alu");
        chk("ovf_count_model", 64'(ovf_count), 64'(exp_ovf));

        // Continuous stream across pointer wrap with random downstream stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m = add_model(32'h1000 * i, 32'h7FFFFFF0 + i);
            push_op(32'h1000 * i, 32'h7FFFFFF0 + i, 4'(i), m[31:0], m[32]);
        end
        drain();

        // Overflow counting from a clean count, then saturation.
        rst = 1'b1; #1; cycle(); rst = 1'b0;
        for (int i = 0; i < 3; i++) push_op(32'h7FFFFFFF, 32'h1, 4'h7, 32'h80000000, 1'b1);
        drain();
        chk("ovf_count_3", 64'(ovf_count), 64'd3);
        for (int i = 0; i < 300; i++) begin
            m = add_model(32'h40000000 + i, 32'h40000000);
            push_op(32'h40000000 + i, 32'h40000000, 4'h9, m[31:0], m[32]);
        end
        drain();
        chk("ovf_count_sat", 64'(ovf_count), 64'd255);
        chk("ovf_model_sat", 64'(exp_ovf), 64'(ovf_count));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
